// File: rtl/xcvr_lock_supervisor_if.sv
// Bundles the PLL lock inputs and the supervisor's status/reset outputs.
// master = the side driving lock flags and clear_cnt; slave = the supervisor.
interface xcvr_lock_supervisor_if #(
  parameter int N_PLL     = 3,
  parameter int LOL_CNT_W = 8
);
  logic [N_PLL-1:0]           pll_locked_async;
  logic                       clear_cnt;
  logic                       system_reset_n;
  logic                       all_locked;
  logic [N_PLL-1:0]           lock_stable;
  logic [N_PLL*LOL_CNT_W-1:0] lol_count;
  logic [3:0]                 retry_count;
  logic [1:0]                 state;
  logic [3:0]                 led_n;

  modport master (
    output pll_locked_async, clear_cnt,
    input  system_reset_n, all_locked, lock_stable, lol_count, retry_count, state, led_n
  );

  modport slave (
    input  pll_locked_async, clear_cnt,
    output system_reset_n, all_locked, lock_stable, lol_count, retry_count, state, led_n
  );
endinterface

// File: rtl/xcvr_lock_supervisor.sv
// Filters transceiver PLL lock flags, sequences the system reset with timed retries,
// counts loss-of-lock events and drives status LEDs. LOCK_SUP_HEARTBEAT_EN adds a heartbeat on led_n[3].
module xcvr_lock_supervisor #(
  parameter int N_PLL               = 3,
  parameter int POR_CYCLES          = 27'h700_0000,
  parameter int LOCK_STABLE_CYCLES  = 50000,
  parameter int LOCK_TIMEOUT_CYCLES = 5000000,
  parameter int RESET_PULSE_CYCLES  = 1000,
  parameter int LOL_CNT_W           = 8,
  parameter int BLINK_BIT           = 26
) (
  input  logic                  clk_50,
  input  logic                  cpu_resetn,
  xcvr_lock_supervisor_if.slave bus
);
  localparam int TIMER_MAX = (POR_CYCLES > LOCK_TIMEOUT_CYCLES)
                           ? ((POR_CYCLES > RESET_PULSE_CYCLES) ? POR_CYCLES : RESET_PULSE_CYCLES)
                           : ((LOCK_TIMEOUT_CYCLES > RESET_PULSE_CYCLES) ? LOCK_TIMEOUT_CYCLES : RESET_PULSE_CYCLES);
  localparam int TIMER_W = $clog2(TIMER_MAX + 1);
  localparam int FILT_W  = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [TIMER_W-1:0] POR_T     = TIMER_W'(POR_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_T   = TIMER_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_T    = FILT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_POR         = 2'd0,
    S_WAIT_LOCK   = 2'd1,
    S_RUN         = 2'd2,
    S_RESET_PULSE = 2'd3
  } state_t;

  logic [N_PLL-1:0]   sync1_reg;
  logic [N_PLL-1:0]   sync2_reg;
  logic [N_PLL-1:0]   stable_vec;
  logic               all_locked_reg;
  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [3:0]         retry_reg, retry_next;
  logic               retry_inc;
  logic               sys_rst_n_reg;

  if (N_PLL < 1 || N_PLL > 4 || BLINK_BIT < 0 || BLINK_BIT > 26) begin : g_param_check
    $error("xcvr_lock_supervisor: N_PLL must be 1..4 and BLINK_BIT 0..26");
  end

  // Two-flop synchroniser for the asynchronous lock flags
  always_ff @(posedge clk_50 or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.pll_locked_async;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_PLL; gi++) begin : g_pll
    logic [FILT_W-1:0]    filt_cnt_reg;
    logic                 stable_reg;
    logic                 stable_d_reg;
    logic [LOL_CNT_W-1:0] lol_reg;
    logic                 lol_evt;

    assign lol_evt = stable_d_reg & ~stable_reg;

    // Counter parks at its terminal value so a long lock never wraps back below it
    always_ff @(posedge clk_50 or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
        filt_cnt_reg <= '0;
        stable_reg   <= 1'b0;
      end else if (!sync2_reg[gi]) begin
        filt_cnt_reg <= '0;
        stable_reg   <= 1'b0;
      end else if (filt_cnt_reg == FILT_T) begin
        stable_reg   <= 1'b1;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end

    always_ff @(posedge clk_50 or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
        stable_d_reg <= 1'b0;
        lol_reg      <= '0;
      end else begin
        stable_d_reg <= stable_reg;
        if (bus.clear_cnt)
          lol_reg <= lol_evt ? LOL_CNT_W'(1) : '0;
        else if (lol_evt && (lol_reg != '1))
          lol_reg <= lol_reg + 1'b1;
      end
    end

    assign stable_vec[gi] = stable_reg;
    assign bus.lol_count[gi*LOL_CNT_W +: LOL_CNT_W] = lol_reg;
  end

  always_ff @(posedge clk_50 or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      all_locked_reg <= 1'b0;
      state_reg      <= S_POR;
      timer_reg      <= '0;
      retry_reg      <= '0;
      sys_rst_n_reg  <= 1'b0;
    end else begin
      all_locked_reg <= &stable_vec;
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      retry_reg      <= retry_next;
      sys_rst_n_reg  <= (state_next == S_WAIT_LOCK) || (state_next == S_RUN);
    end
  end

  // The timer is zeroed on every state change so each state measures from its own entry
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 1'b1;
    retry_inc  = 1'b0;
    case (state_reg)
      S_POR: begin
        if (timer_reg == POR_T) begin
          state_next = S_WAIT_LOCK;
          timer_next = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (all_locked_reg) begin
          state_next = S_RUN;
          timer_next = '0;
        end else if (timer_reg == TIMEOUT_T) begin
          state_next = S_RESET_PULSE;
          timer_next = '0;
          retry_inc  = 1'b1;
        end
      end
      S_RUN: begin
        timer_next = '0;
        if (!all_locked_reg)
          state_next = S_RESET_PULSE;
      end
      S_RESET_PULSE: begin
        if (timer_reg == PULSE_T) begin
          state_next = S_WAIT_LOCK;
          timer_next = '0;
        end
      end
      default: begin
        state_next = S_POR;
        timer_next = '0;
      end
    endcase

    retry_next = retry_reg;
    if (bus.clear_cnt)
      retry_next = retry_inc ? 4'd1 : 4'd0;
    else if (retry_inc && (retry_reg != 4'hF))
      retry_next = retry_reg + 4'd1;
  end

  assign bus.system_reset_n = sys_rst_n_reg;
  assign bus.all_locked     = all_locked_reg;
  assign bus.lock_stable    = stable_vec;
  assign bus.retry_count    = retry_reg;
  assign bus.state          = state_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_led
    if (gi < N_PLL) begin : g_used
      assign bus.led_n[gi] = ~stable_vec[gi];
    end else begin : g_unused
      assign bus.led_n[gi] = 1'b1;
    end
  end

`ifdef LOCK_SUP_HEARTBEAT_EN
  logic [26:0] heartbeat_reg;

  always_ff @(posedge clk_50 or negedge cpu_resetn) begin
    if (!cpu_resetn)
      heartbeat_reg <= '0;
    else
      heartbeat_reg <= heartbeat_reg + 1'b1;
  end

  assign bus.led_n[3] = heartbeat_reg[BLINK_BIT];
`else
  assign bus.led_n[3] = (state_reg != S_RUN);
`endif
endmodule

// File: tb/tb_xcvr_lock_supervisor.sv
// Scoreboard bench for xcvr_lock_supervisor: directed scenarios plus randomized lock traffic,
// expected outputs come from a per-edge behavioural model and are compared at each falling edge.
module tb_xcvr_lock_supervisor;
  localparam int N   = 3;
  localparam int W   = 8;
  localparam int P   = 100;
  localparam int L   = 8;
  localparam int TO  = 200;
  localparam int RP  = 16;
  localparam int BB  = 3;
  localparam int SAT = (1 << W) - 1;

  typedef struct packed {
    logic         srn;
    logic         al;
    logic [N-1:0] ls;
    logic [N*W-1:0] lol;
    logic [3:0]   retry;
    logic [1:0]   st;
    logic [3:0]   led;
  } exp_t;

  logic clk_50;
  logic cpu_resetn;

  xcvr_lock_supervisor_if #(.N_PLL(N), .LOL_CNT_W(W)) bus ();

  xcvr_lock_supervisor #(
    .N_PLL(N), .POR_CYCLES(P), .LOCK_STABLE_CYCLES(L), .LOCK_TIMEOUT_CYCLES(TO),
    .RESET_PULSE_CYCLES(RP), .LOL_CNT_W(W), .BLINK_BIT(BB)
  ) dut (
    .clk_50(clk_50),
    .cpu_resetn(cpu_resetn),
    .bus(bus)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: edges since reset release, input history and derived outputs
  int           m_e, m_state, m_t0, m_retry;
  int           m_lol [N];
  logic [N-1:0] m_ls, m_ls_prev;
  logic         m_al;
  logic [N-1:0] a_hist[$];
  logic [N-1:0] s_hist[$];

  function automatic void model_reset();
    m_e = 0; m_state = 0; m_t0 = 0; m_retry = 0;
    for (int i = 0; i < N; i++) m_lol[i] = 0;
    m_ls = '0; m_ls_prev = '0; m_al = 1'b0;
    a_hist.delete();
    s_hist.delete();
  endfunction

  // lock_stable = synchronised flag high on each of the last L edges;
  // synchronised flag at an edge = raw flag sampled two edges earlier
  function automatic void model_edge(input logic [N-1:0] pll, input logic clr);
    logic [N-1:0] sync_now, ls_new;
    logic         al_new, fire;
    m_e++;
    a_hist.push_back(pll);
    sync_now = (a_hist.size() >= 3) ? a_hist[a_hist.size()-3] : '0;
    if (a_hist.size() > 3) void'(a_hist.pop_front());
    s_hist.push_back(sync_now);
    if (s_hist.size() > L) void'(s_hist.pop_front());
    ls_new = (s_hist.size() == L) ? '1 : '0;
    foreach (s_hist[k]) ls_new = ls_new & s_hist[k];
    al_new = &m_ls;

    for (int i = 0; i < N; i++) begin
      logic ev;
      ev = m_ls_prev[i] & ~m_ls[i];
      if (clr) m_lol[i] = ev ? 1 : 0;
      else if (ev && m_lol[i] < SAT) m_lol[i]++;
    end

    fire = 1'b0;
    case (m_state)
      0: if (m_e == P + 1) begin m_state = 1; m_t0 = m_e; end
      1: if (m_al) begin m_state = 2; m_t0 = m_e; end
         else if (m_e - m_t0 == TO) begin m_state = 3; m_t0 = m_e; fire = 1'b1; end
      2: if (!m_al) begin m_state = 3; m_t0 = m_e; end
      default: if (m_e - m_t0 == RP) begin m_state = 1; m_t0 = m_e; end
    endcase
    if (clr) m_retry = fire ? 1 : 0;
    else if (fire && m_retry < 15) m_retry++;

    m_ls_prev = m_ls;
    m_ls      = ls_new;
    m_al      = al_new;
  endfunction

  function automatic exp_t snap();
    exp_t x;
    x.srn   = (m_state == 1) || (m_state == 2);
    x.al    = m_al;
    x.ls    = m_ls;
    for (int i = 0; i < N; i++) x.lol[i*W +: W] = W'(m_lol[i]);
    x.retry = 4'(m_retry);
    x.st    = 2'(m_state);
    x.led   = 4'hF;
    for (int i = 0; i < 3 && i < N; i++) x.led[i] = ~m_ls[i];
`ifdef LOCK_SUP_HEARTBEAT_EN
    x.led[3] = 1'((m_e >> BB) & 1);
`else
    x.led[3] = (m_state != 2);
`endif
    return x;
  endfunction

  // Called just after a rising edge: sets inputs for the next edge and queues the
  // outputs expected at the coming falling edge
  task automatic cycle(input logic [N-1:0] pll, input logic clr, input logic rstn);
    bus.pll_locked_async = pll;
    bus.clear_cnt        = clr;
    cpu_resetn           = rstn;
    if (!rstn) model_reset();
    exp_q.push_back(snap());
    @(posedge clk_50);
    #2;
    if (rstn) model_edge(pll, clr);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
  endtask

  always @(negedge clk_50) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("system_reset_n", 64'(bus.system_reset_n), 64'(e.srn));
      check("all_locked",     64'(bus.all_locked),     64'(e.al));
      check("lock_stable",    64'(bus.lock_stable),    64'(e.ls));
      check("lol_count",      64'(bus.lol_count),      64'(e.lol));
      check("retry_count",    64'(bus.retry_count),    64'(e.retry));
      check("state",          64'(bus.state),          64'(e.st));
      check("led_n",          64'(bus.led_n),          64'(e.led));
    end
  end

  initial begin
    logic [N-1:0] rv;
    int           len;
    logic         rclr;
    bus.pll_locked_async = '0;
    bus.clear_cnt        = 1'b0;
    cpu_resetn           = 1'b1;
    model_reset();
    #1 cpu_resetn = 1'b0;
    @(posedge clk_50);
    #2;
    repeat (3) cycle('0, 1'b0, 1'b0);

    // All PLLs locked from reset: power-on sequence into RUN
    repeat (130) cycle(3'b111, 1'b0, 1'b1);
    // PLL2 drops briefly while running
    repeat (3)   cycle(3'b011, 1'b0, 1'b1);
    repeat (60)  cycle(3'b111, 1'b0, 1'b1);

    // Fresh start: PLL1 glitches 5 cycles, otherwise no lock -> timeout and retry pulse
    repeat (2)   cycle('0, 1'b0, 1'b0);
    repeat (20)  cycle('0, 1'b0, 1'b1);
    repeat (5)   cycle(3'b010, 1'b0, 1'b1);
    repeat (279) cycle('0, 1'b0, 1'b1);
    // Reset asserted in the middle of the retry pulse, then a full restart
    repeat (2)   cycle(3'b111, 1'b0, 1'b0);
    repeat (120) cycle(3'b111, 1'b0, 1'b1);
    cycle(3'b111, 1'b1, 1'b1);

    // Saturate PLL0's loss-of-lock counter, then clear coincident with a loss event
    for (int k = 0; k < 262; k++) begin
      repeat (11) cycle(3'b111, 1'b0, 1'b1);
      repeat (3)  cycle(3'b110, 1'b0, 1'b1);
    end
    repeat (11) cycle(3'b111, 1'b0, 1'b1);
    repeat (3)  cycle(3'b110, 1'b0, 1'b1);
    cycle(3'b111, 1'b1, 1'b1);
    repeat (20) cycle(3'b111, 1'b0, 1'b1);

    // Randomized lock traffic with sporadic clears and resets
    for (int s = 0; s < 80; s++) begin
      rv  = N'($urandom_range(0, (1 << N) - 1));
      len = int'($urandom_range(1, 24));
      if ($urandom_range(0, 3) == 0) rv = '1;
      if ($urandom_range(0, 40) == 0) cycle(rv, 1'b0, 1'b0);
      for (int c = 0; c < len; c++) begin
        rclr = ($urandom_range(0, 15) == 0);
        cycle(rv, rclr, 1'b1);
      end
    end
    repeat (300) cycle('0, 1'b0, 1'b1);

    @(negedge clk_50);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
